// File: rtl/audio_decimator_pkg.sv
// Shared types, constants and saturation helpers for the audio decimation front end.
package audio_pkg;

  typedef logic signed [7:0] audio_sample_t;

  localparam logic [11:0]        ADC_MIDSCALE = 12'd2048;
  localparam logic signed [20:0] SAT_MAX      = 21'sd127;
  localparam logic signed [20:0] SAT_MIN      = -21'sd128;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } decim_state_t;

  function automatic logic is_clipped(input logic signed [20:0] value);
    return (value > SAT_MAX) || (value < SAT_MIN);
  endfunction

  function automatic audio_sample_t saturate(input logic signed [20:0] value);
    audio_sample_t result;
    if (value > SAT_MAX) begin
      result = 8'sh7F;
    end else if (value < SAT_MIN) begin
      result = 8'sh80;
    end else begin
      result = value[7:0];
    end
    return result;
  endfunction

endpackage

// File: rtl/audio_decimator_dc_blocker.sv
// First-order DC tracker: the first block after reset seeds the estimate, and
// every later block emits its offset from the estimate, then nudges the estimate.
module dc_blocker #(
  parameter int DC_SHIFT = 4
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [12:0] avg_in,
  input  logic        avg_valid_in,
  output logic [13:0] centered_out,
  output logic        centered_valid_out
);
  import audio_pkg::*;

  decim_state_t       state_r;
  decim_state_t       next_state_s;
  logic signed [12:0] dc_r;
  logic signed [12:0] dc_next_s;
  logic signed [12:0] avg_s;
  logic signed [13:0] diff_s;
  logic signed [13:0] step_s;
  logic signed [13:0] centered_r;
  logic               centered_valid_r;
  logic               load_dc_s;
  logic               emit_s;

  // Next-state decode and tracker arithmetic (diff uses the pre-update estimate)
  always_comb begin
    next_state_s = state_r;
    load_dc_s    = 1'b0;
    emit_s       = 1'b0;
    avg_s        = $signed(avg_in);
    diff_s       = {avg_s[12], avg_s} - {dc_r[12], dc_r};
    step_s       = diff_s >>> DC_SHIFT;
    dc_next_s    = dc_r + step_s[12:0];
    case (state_r)
      INIT: begin
        if (avg_valid_in) begin
          next_state_s = RUN;
          load_dc_s    = 1'b1;
        end else begin
          next_state_s = INIT;
        end
      end
      RUN: begin
        next_state_s = RUN;
        emit_s       = avg_valid_in;
      end
      default: begin
        next_state_s = INIT;
      end
    endcase
  end

  // State register; only reset returns the tracker to INIT
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_r <= INIT;
    end else begin
      state_r <= next_state_s;
    end
  end

  // DC estimate and centered-sample registers
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      dc_r             <= '0;
      centered_r       <= '0;
      centered_valid_r <= 1'b0;
    end else begin
      centered_valid_r <= emit_s;
      if (load_dc_s) begin
        dc_r <= avg_s;
      end else if (emit_s) begin
        dc_r       <= dc_next_s;
        centered_r <= diff_s;
      end
    end
  end

  assign centered_out       = centered_r;
  assign centered_valid_out = centered_valid_r;

endmodule

// File: rtl/audio_decimator.sv
// ADC conditioning front end: boxcar decimation, DC removal, power-of-two gain
// and saturation to signed 8-bit with a sticky clip flag.
module audio_decimator #(
  parameter int DECIM      = 8,
  parameter int LOG2_DECIM = 3,
  parameter int DC_SHIFT   = 4
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [11:0] sample_in,
  input  logic        sample_valid_in,
  input  logic [2:0]  gain_in,
  input  logic        mute_in,
  input  logic        clip_clear_in,
  output logic [7:0]  audio_out,
  output logic        audio_valid_out,
  output logic        clip_out
);
  import audio_pkg::*;

  localparam int                    ACC_W     = 12 + LOG2_DECIM;
  localparam int                    GAIN_FRAC = 4;
  localparam logic [LOG2_DECIM-1:0] LAST_CNT  = LOG2_DECIM'(DECIM - 1);

  logic [ACC_W-1:0]      acc_r;
  logic [ACC_W-1:0]      sum_s;
  logic [LOG2_DECIM-1:0] cnt_r;
  logic                  block_done_s;
  logic signed [12:0]    avg_s;
  logic signed [12:0]    avg_r;
  logic                  avg_valid_r;
  logic [13:0]           centered_s;
  logic                  centered_valid_s;
  logic signed [20:0]    centered_ext_s;
  logic signed [20:0]    shifted_s;
  logic signed [20:0]    scaled_s;
  logic                  clip_hit_s;
  audio_sample_t         audio_r;
  logic                  audio_valid_r;
  logic                  clip_r;

  // Running block sum including the sample presented this cycle
  always_comb begin
    sum_s = acc_r + ACC_W'(sample_in);
    if (sample_valid_in && (cnt_r == LAST_CNT)) begin
      block_done_s = 1'b1;
    end else begin
      block_done_s = 1'b0;
    end
    avg_s = $signed({1'b0, sum_s[ACC_W-1:LOG2_DECIM]}) - $signed({1'b0, ADC_MIDSCALE});
  end

  // Block accumulator and sample counter; a reset mid-block drops the partial sum
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      acc_r <= '0;
      cnt_r <= '0;
    end else if (block_done_s) begin
      acc_r <= '0;
      cnt_r <= '0;
    end else if (sample_valid_in) begin
      acc_r <= sum_s;
      cnt_r <= cnt_r + LOG2_DECIM'(1);
    end
  end

  // Stage 1: block average re-centred on mid-scale
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      avg_r       <= '0;
      avg_valid_r <= 1'b0;
    end else begin
      avg_valid_r <= block_done_s;
      if (block_done_s) begin
        avg_r <= avg_s;
      end
    end
  end

  dc_blocker #(
    .DC_SHIFT(DC_SHIFT)
  ) u_dc_blocker (
    .clk_in            (clk_in),
    .rst_in            (rst_in),
    .avg_in            (avg_r),
    .avg_valid_in      (avg_valid_r),
    .centered_out      (centered_s),
    .centered_valid_out(centered_valid_s)
  );

  // Stage 2 arithmetic: gain applied as <<gain then >>4, so gain 4 is unity
  always_comb begin
    centered_ext_s = {{7{centered_s[13]}}, centered_s};
    shifted_s      = centered_ext_s <<< gain_in;
    scaled_s       = shifted_s >>> GAIN_FRAC;
    if (centered_valid_s) begin
      clip_hit_s = is_clipped(scaled_s);
    end else begin
      clip_hit_s = 1'b0;
    end
  end

  // Output register and sticky clip flag; a new saturation beats a clear
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      audio_r       <= 8'sh00;
      audio_valid_r <= 1'b0;
      clip_r        <= 1'b0;
    end else begin
      audio_valid_r <= centered_valid_s;
      if (centered_valid_s) begin
        audio_r <= mute_in ? 8'sh00 : saturate(scaled_s);
      end
      if (clip_hit_s) begin
        clip_r <= 1'b1;
      end else if (clip_clear_in) begin
        clip_r <= 1'b0;
      end
    end
  end

  assign audio_out       = audio_r;
  assign audio_valid_out = audio_valid_r;
  assign clip_out        = clip_r;

endmodule

// File: tb/tb_audio_decimator.sv
// Bench for audio_decimator: directed phases with randomized samples, gaps and
// gains, checked against a block-level arithmetic model of the conditioning chain.
module tb_audio_decimator;

  localparam int DECIM      = 4;
  localparam int LOG2_DECIM = 2;
  localparam int DC_SHIFT   = 4;

  logic        clk_in;
  logic        rst_in;
  logic [11:0] sample_in;
  logic        sample_valid_in;
  logic [2:0]  gain_in;
  logic        mute_in;
  logic        clip_clear_in;
  logic [7:0]  audio_out;
  logic        audio_valid_out;
  logic        clip_out;

  audio_decimator #(
    .DECIM     (DECIM),
    .LOG2_DECIM(LOG2_DECIM),
    .DC_SHIFT  (DC_SHIFT)
  ) dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .sample_in      (sample_in),
    .sample_valid_in(sample_valid_in),
    .gain_in        (gain_in),
    .mute_in        (mute_in),
    .clip_clear_in  (clip_clear_in),
    .audio_out      (audio_out),
    .audio_valid_out(audio_valid_out),
    .clip_out       (clip_out)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  typedef struct {
    int due;
    int cen;
  } pend_t;

  pend_t pend_q[$];
  int    block_q[$];
  int    n_checks;
  int    n_errors;
  int    cyc;
  bit    first_blk;
  int    dc_m;
  int    last_out;
  bit    clip_m;

  function automatic int floor_div(input int a, input int b);
    int q;
    q = a / b;
    if ((a % b != 0) && (a < 0)) q = q - 1;
    return q;
  endfunction

  task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s at cycle %0d: observed %0d expected %0d", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    block_q.delete();
    pend_q.delete();
    first_blk = 1'b1;
    dc_m      = 0;
    last_out  = 0;
    clip_m    = 1'b0;
  endtask

  // Block-level model: average, seed or track DC, queue the centered value with its due cycle
  task automatic model_add(input int v);
    int sum;
    int avg;
    int cen;
    block_q.push_back(v);
    if (block_q.size() == DECIM) begin
      sum = 0;
      foreach (block_q[i]) sum += block_q[i];
      block_q.delete();
      avg = sum / DECIM - 2048;
      if (first_blk) begin
        dc_m      = avg;
        first_blk = 1'b0;
      end else begin
        cen  = avg - dc_m;
        dc_m = dc_m + floor_div(cen, 1 << DC_SHIFT);
        pend_q.push_back('{cyc + 3, cen});
      end
    end
  endtask

  task automatic tick();
    bit exp_v;
    bit sat;
    int v;
    @(posedge clk_in);
    #1;
    cyc++;
    sat   = 1'b0;
    exp_v = (pend_q.size() > 0) && (pend_q[0].due == cyc);
    chk("audio_valid", audio_valid_out, exp_v);
    if (exp_v) begin
      v   = floor_div(pend_q[0].cen * (1 << gain_in), 16);
      sat = (v > 127) || (v < -128);
      if (v > 127) v = 127;
      else if (v < -128) v = -128;
      if (mute_in) v = 0;
      last_out = v;
      void'(pend_q.pop_front());
    end
    chk("audio_out", $signed(audio_out), last_out);
    if (sat) clip_m = 1'b1;
    else if (clip_clear_in) clip_m = 1'b0;
    chk("clip_out", clip_out, clip_m);
  endtask

  task automatic send(input int v, input int gap);
    sample_in       = 12'(v);
    sample_valid_in = 1'b1;
    model_add(v);
    tick();
    sample_valid_in = 1'b0;
    sample_in       = 12'($urandom);
    repeat (gap) tick();
  endtask

  task automatic clear_pulse();
    clip_clear_in = 1'b1;
    tick();
    clip_clear_in = 1'b0;
  endtask

  task automatic do_reset(input int hold);
    sample_valid_in = 1'b0;
    rst_in          = 1'b0;
    #1;
    model_reset();
    chk("rst_valid", audio_valid_out, 0);
    chk("rst_audio", $signed(audio_out), 0);
    chk("rst_clip", clip_out, 0);
    repeat (hold) tick();
    rst_in = 1'b1;
  endtask

  initial begin
    n_checks        = 0;
    n_errors        = 0;
    cyc             = 0;
    rst_in          = 1'b1;
    sample_in       = 12'd0;
    sample_valid_in = 1'b0;
    gain_in         = 3'd0;
    mute_in         = 1'b0;
    clip_clear_in   = 1'b0;
    model_reset();
    #2;
    do_reset(3);

    // Constant 2560 back-to-back, then step to 2816 at gain 0
    repeat (5 * DECIM) send(2560, 0);
    repeat (6 * DECIM) send(2816, 0);
    repeat (4) tick();

    // Same step at gain 3 with clear pulses between blocks
    do_reset(2);
    gain_in = 3'd3;
    repeat (2 * DECIM) send(2560, 0);
    for (int b = 0; b < 4; b++) begin
      repeat (DECIM) send(2816, 0);
      clear_pulse();
      repeat (2) tick();
    end

    // Step down to 2304 at gain 3
    do_reset(2);
    repeat (2 * DECIM) send(2560, 0);
    repeat (3 * DECIM) send(2304, 0);
    repeat (4) tick();
    clear_pulse();

    // Jittered spacing around 5 cycles, same step pattern at gain 0
    do_reset(2);
    gain_in = 3'd0;
    repeat (3 * DECIM) send(2560, int'($urandom_range(2, 6)));
    repeat (4 * DECIM) send(2816, int'($urandom_range(2, 6)));

    // Random samples, gains and gaps with occasional clears
    for (int i = 0; i < 12 * DECIM; i++) begin
      gain_in = 3'($urandom);
      send(int'($urandom_range(0, 4095)), int'($urandom_range(0, 3)));
      if ($urandom_range(0, 7) == 0) clear_pulse();
    end
    repeat (4) tick();

    // Reset mid-block, fresh INIT block, then a muted step and unmute
    do_reset(2);
    gain_in = 3'd0;
    repeat (2 * DECIM) send(2560, 0);
    repeat (2) send(2560, 0);
    do_reset(2);
    repeat (DECIM) send(2560, 0);
    repeat (DECIM) send(2560, 0);
    mute_in = 1'b1;
    repeat (3 * DECIM) send(2816, 0);
    repeat (3) tick();
    mute_in = 1'b0;
    repeat (3 * DECIM) send(2816, 0);
    repeat (6) tick();

    chk("drain", pend_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
